mem_port_arbiter: RTL

Shares one single-port synchronous SRAM between the instruction-fetch (IF) stage and the MEM stage of the pipelined ARM-subset core. The MEM side is driven by the decoder's MEM_R_EN/MEM_W_EN (LDR/STR). The block sequences each access through a fixed wait-state counter and returns a one-cycle ready pulse with registered read data. It also produces the pipeline freeze for pending data accesses.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_wait_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port SRAM arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DATA_ACC   = 3'd1,
    FETCH_ACC  = 3'd2,
    RESP_DATA  = 3'd3,
    RESP_FETCH = 3'd4
  } state_t;

  typedef enum logic {
    PRIO_DATA  = 1'b0,
    PRIO_FETCH = 1'b1
  } prio_t;

  function automatic logic is_acc(input state_t s);
    return (s == DATA_ACC) || (s == FETCH_ACC);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-state counter: cleared at access start, counts while enabled,
// flags the last wait cycle combinationally.
module wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = en && (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access,
// with alternating priority, fixed wait states and a one-cycle ready pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_t state, state_nx;
  prio_t  prio;
  logic   data_req_c;
  logic   start_c;
  logic   acc_c;
  logic   tc_c;

  assign data_req_c = mem_r_en | mem_w_en;
  assign acc_c      = is_acc(state);
  assign start_c    = (state == IDLE) && is_acc(state_nx);
  assign freeze     = data_req_c & ~mem_ready;

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(start_c),
    .en   (acc_c),
    .tc_c (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: on contention the side named by prio wins.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (data_req_c && (!if_req || (prio == PRIO_DATA))) begin
          state_nx = DATA_ACC;
        end else if (if_req) begin
          state_nx = FETCH_ACC;
        end
      end
      DATA_ACC:   if (tc_c) state_nx = RESP_DATA;
      FETCH_ACC:  if (tc_c) state_nx = RESP_FETCH;
      RESP_DATA:  state_nx = IDLE;
      RESP_FETCH: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // SRAM request latches, ready pulses, read-data capture and priority flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= PRIO_DATA;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      sram_en   <= is_acc(state_nx);
      if_ready  <= (state_nx == RESP_FETCH);
      mem_ready <= (state_nx == RESP_DATA);

      if (start_c && (state_nx == DATA_ACC)) begin
        sram_addr  <= mem_addr;
        sram_wdata <= mem_wdata;
        sram_we    <= mem_w_en;
      end else if (start_c) begin
        sram_addr <= if_addr;
        sram_we   <= 1'b0;
      end else if (!is_acc(state_nx)) begin
        sram_we <= 1'b0;
      end

      if (acc_c && tc_c) begin
        if (state == DATA_ACC) begin
          mem_rdata <= sram_rdata;
          prio      <= PRIO_FETCH;
        end else begin
          if_rdata <= sram_rdata;
          prio     <= PRIO_DATA;
        end
      end
    end
  end

endmodule
